eth_10base_t_tx_ctrl: RTL and testbench
=======================================

ETH_10BASE_T_TX_CTRL -- requirements
Module: eth_10base_t_tx_ctrl

Interface
REQ-001 SHALL have parameter IPG_CYCLES, default 960, inter-packet gap in clk cycles (9.6 us at 100 MHz).
REQ-002 SHALL have parameter NLP_PERIOD, default 1600000, idle cycles between normal link pulses (16 ms at 100 MHz).
REQ-003 SHALL have parameter PRE_LEN, default 7, number of 0x55 preamble bytes.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 s0_data / s1_data  input  8  frame byte from requester 0 / 1.
REQ-007 s0_valid / s1_valid  input  1  requester byte valid; first valid in IDLE is a frame request.
REQ-008 s0_last / s1_last  input  1  marks final byte of frame.
REQ-009 s0_ready / s1_ready  output  1  requester byte accepted when valid && ready.
REQ-010 tx_data  output  8  byte to 10BASE-T transmitter.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_last  output  1  final frame byte.
REQ-013 tx_ready  input  1  transmitter accepts byte when tx_valid && tx_ready.
REQ-014 nlp_pulse  output  1  one-cycle strobe requesting a normal link pulse.
REQ-015 gnt  output  2  one-hot current grant, 00 when no frame owned.
REQ-016 led_tx  output  1  high in PREAMBLE, SFD, DATA.

Function
REQ-017 SHALL implement states IDLE, PREAMBLE, SFD, DATA, IPG.
REQ-018 IDLE: arbitrate s0_valid/s1_valid round-robin; single requester wins; both valid -> source not granted last wins; first arbitration after reset favours s0.
REQ-019 IDLE -> PREAMBLE on grant; gnt registered same edge, held until DATA -> IPG.
REQ-020 PREAMBLE: tx_valid=1, tx_data=0x55, tx_last=0; byte counter advances only on tx_ready; after PRE_LEN accepted bytes -> SFD.
REQ-021 SFD: tx_valid=1, tx_data=0xD5; on tx_ready -> DATA.
REQ-022 DATA: tx_data/tx_valid/tx_last combinationally = granted source data/valid/last; granted sN_ready = tx_ready; other sN_ready=0.
REQ-023 DATA: tx_valid low when source valid low (bubble passed through, no state change).
REQ-024 DATA -> IPG on accepted byte with last=1; IPG counter loaded IPG_CYCLES-1.
REQ-025 IPG: tx_valid=0, all sN_ready=0; counter decrements each cycle; at 0 -> IDLE, so exactly IPG_CYCLES cycles between last accept and earliest next preamble byte.
REQ-026 sN_ready SHALL be 0 in every state except DATA.
REQ-027 NLP timer counts only in IDLE, cleared on any exit from IDLE.
REQ-028 Timer reaching NLP_PERIOD-1 in IDLE with no valid request: nlp_pulse=1 one cycle, timer clears, stay IDLE.
REQ-029 Timer expiry same cycle as a request: frame wins, nlp_pulse=0, timer clears.
REQ-030 Counters SHALL be sized by $clog2 of their parameter; no wrap beyond terminal count.
REQ-031 Requester deasserting valid in IDLE before grant is not an error; no grant issued.

Reset
REQ-032 resetn low SHALL immediately force: state IDLE, gnt=00, tx_valid=0, tx_data=0x00, tx_last=0, s0_ready=s1_ready=0, nlp_pulse=0, led_tx=0, all counters 0, round-robin pointer to favour s0.
REQ-033 Reset mid-frame SHALL abort the frame with no IPG; after release first request restarts at PREAMBLE.
REQ-034 Outputs SHALL remain at reset values until first rising clk after resetn high.

Verification
REQ-035 s0 sends 3 bytes 0x11,0x22,0x33(last), tx_ready=1 -> tx_data 55x7, D5, 11, 22, 33 with tx_last on 33, gnt=01, led_tx high 11 cycles.
REQ-036 s0 and s1 valid together twice back-to-back -> grants order s0, s1, s0; next preamble starts exactly IPG_CYCLES cycles after last accept.
REQ-037 tx_ready toggling 1/0 in PREAMBLE and DATA -> byte sequence unchanged, no byte lost or duplicated, sN_ready mirrors tx_ready.
REQ-038 NLP_PERIOD=20, no traffic 100 cycles -> nlp_pulse every 20 cycles, single-cycle; request on expiry cycle -> no pulse, frame starts.
REQ-039 resetn low during DATA byte 2 -> all outputs zero asynchronously; after release a new s1 frame begins with 0x55 and gnt=10.
REQ-040 IPG_CYCLES=4 -> exactly 4 cycles tx_valid=0 between tx_last accept and next 0x55.

Source files
------------

// File: rtl/eth_10base_t_tx_ctrl.sv
// 10BASE-T transmit controller: round-robin arbitration of two byte streams,
// preamble/SFD insertion, inter-packet gap timing and normal-link-pulse generation.
module eth_10base_t_tx_ctrl #(
  parameter int unsigned IPG_CYCLES = 960,
  parameter int unsigned NLP_PERIOD = 1600000,
  parameter int unsigned PRE_LEN    = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       nlp_pulse,
  output logic [1:0] gnt,
  output logic       led_tx
);

  localparam int unsigned PreW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam int unsigned IpgW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam int unsigned NlpW = (NLP_PERIOD > 1) ? $clog2(NLP_PERIOD) : 1;

  localparam logic [PreW-1:0] PreLast = PreW'(PRE_LEN - 1);
  localparam logic [IpgW-1:0] IpgLoad = IpgW'(IPG_CYCLES - 1);
  localparam logic [IpgW-1:0] IpgOne  = IpgW'(1);
  localparam logic [NlpW-1:0] NlpLast = NlpW'(NLP_PERIOD - 1);

  typedef enum logic [2:0] {StIdle, StPreamble, StSfd, StData, StIpg} state_e;

  state_e          state_q;
  logic [1:0]      gnt_q;
  logic            rr_last_s1_q;  // set: s1 was granted last, so s0 wins the next tie
  logic [PreW-1:0] pre_cnt_q;
  logic [IpgW-1:0] ipg_cnt_q;
  logic [NlpW-1:0] nlp_cnt_q;
  logic            nlp_pulse_q;

  logic       src_valid;
  logic       src_last;
  logic [7:0] src_data;
  logic       pick_s1;

  assign src_valid = gnt_q[1] ? s1_valid : s0_valid;
  assign src_last  = gnt_q[1] ? s1_last  : s0_last;
  assign src_data  = gnt_q[1] ? s1_data  : s0_data;
  assign pick_s1   = s1_valid & (~s0_valid | ~rr_last_s1_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      gnt_q        <= 2'b00;
      rr_last_s1_q <= 1'b1;
      pre_cnt_q    <= '0;
      ipg_cnt_q    <= '0;
      nlp_cnt_q    <= '0;
      nlp_pulse_q  <= 1'b0;
    end else begin
      nlp_pulse_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // A request always beats a coincident link-pulse expiry.
          if (s0_valid || s1_valid) begin
            state_q      <= StPreamble;
            gnt_q        <= pick_s1 ? 2'b10 : 2'b01;
            rr_last_s1_q <= pick_s1;
            pre_cnt_q    <= '0;
            nlp_cnt_q    <= '0;
          end else if (nlp_cnt_q == NlpLast) begin
            nlp_pulse_q <= 1'b1;
            nlp_cnt_q   <= '0;
          end else begin
            nlp_cnt_q <= nlp_cnt_q + 1'b1;
          end
        end
        StPreamble: begin
          if (tx_ready) begin
            if (pre_cnt_q == PreLast) begin
              pre_cnt_q <= '0;
              state_q   <= StSfd;
            end else begin
              pre_cnt_q <= pre_cnt_q + 1'b1;
            end
          end
        end
        StSfd: begin
          if (tx_ready) state_q <= StData;
        end
        StData: begin
          if (src_valid && tx_ready && src_last) begin
            state_q   <= StIpg;
            gnt_q     <= 2'b00;
            ipg_cnt_q <= IpgLoad;
          end
        end
        StIpg: begin
          // Leave one cycle early: the IDLE arbitration cycle completes the gap.
          if ((ipg_cnt_q == '0) || (ipg_cnt_q == IpgOne)) begin
            ipg_cnt_q <= '0;
            state_q   <= StIdle;
          end else begin
            ipg_cnt_q <= ipg_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    unique case (state_q)
      StPreamble: begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
      end
      StSfd: begin
        tx_valid = 1'b1;
        tx_data  = 8'hD5;
      end
      StData: begin
        tx_data  = src_data;
        tx_valid = src_valid;
        tx_last  = src_last;
        s0_ready = gnt_q[0] & tx_ready;
        s1_ready = gnt_q[1] & tx_ready;
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign nlp_pulse = nlp_pulse_q;
  assign led_tx    = (state_q == StPreamble) || (state_q == StSfd) || (state_q == StData);

endmodule

// File: tb/tb_eth_10base_t_tx_ctrl.sv
// Directed bench for eth_10base_t_tx_ctrl: expected bytes go into a scoreboard queue
// when frames are queued at the sources and are popped as the transmitter accepts them.
module tb_eth_10base_t_tx_ctrl;

  localparam int unsigned IPG = 4;
  localparam int unsigned NLP = 20;
  localparam int unsigned PRE = 7;

  logic       clk;
  logic       resetn;
  logic [7:0] s0_data, s1_data, tx_data;
  logic       s0_valid, s0_last, s0_ready;
  logic       s1_valid, s1_last, s1_ready;
  logic       tx_valid, tx_last, tx_ready, nlp_pulse, led_tx;
  logic [1:0] gnt;

  eth_10base_t_tx_ctrl #(
    .IPG_CYCLES(IPG),
    .NLP_PERIOD(NLP),
    .PRE_LEN   (PRE)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .s0_data  (s0_data),
    .s0_valid (s0_valid),
    .s0_last  (s0_last),
    .s0_ready (s0_ready),
    .s1_data  (s1_data),
    .s1_valid (s1_valid),
    .s1_last  (s1_last),
    .s1_ready (s1_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .nlp_pulse(nlp_pulse),
    .gnt      (gnt),
    .led_tx   (led_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } src_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] gnt;
    logic       is_data;
  } exp_t;

  src_t src0[$];
  src_t src1[$];
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int nlp_prev = 0;
  int led_cnt = 0;
  int first_valid = -1;
  int last_acc = 0;
  int gaps = 0;
  int start_exp;
  bit nlp_mode = 0;
  bit toggle = 0;
  bit bubble = 0;
  bit gap_armed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int src, input logic [7:0] start, input logic [7:0] step,
                            input int n);
    logic [1:0] g;
    src_t       s;
    g = (src == 0) ? 2'b01 : 2'b10;
    for (int i = 0; i < int'(PRE); i++)
      exp_q.push_back('{data: 8'h55, last: 1'b0, gnt: g, is_data: 1'b0});
    exp_q.push_back('{data: 8'hD5, last: 1'b0, gnt: g, is_data: 1'b0});
    for (int i = 0; i < n; i++) begin
      s.data = start + step * 8'(i);
      s.last = (i == n - 1);
      exp_q.push_back('{data: s.data, last: s.last, gnt: g, is_data: 1'b1});
      if (src == 0) src0.push_back(s);
      else src1.push_back(s);
    end
  endtask

  task automatic drive();
    logic hole;
    hole     = bubble && (cyc % 3 == 2);
    s0_valid = (src0.size() != 0) && !hole;
    s1_valid = (src1.size() != 0) && !hole;
    s0_data  = (src0.size() != 0) ? src0[0].data : 8'h00;
    s0_last  = (src0.size() != 0) ? src0[0].last : 1'b0;
    s1_data  = (src1.size() != 0) ? src1[0].data : 8'h00;
    s1_last  = (src1.size() != 0) ? src1[0].last : 1'b0;
    tx_ready = toggle ? cyc[0] : 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later, then wait.
  task automatic tick();
    exp_t e;
    logic sv;
    drive();
    #1;
    if (!tx_ready) chk("ready_gated", 32'({s0_ready, s1_ready}), 0);
    if (led_tx) led_cnt++;
    if (tx_valid && first_valid < 0) first_valid = cyc;
    if (tx_valid && gap_armed) begin
      chk("ipg_gap", 32'(cyc - last_acc - 1), IPG);
      gaps++;
      gap_armed = 0;
    end
    if (exp_q.size() != 0 && exp_q[0].is_data) begin
      sv = exp_q[0].gnt[0] ? s0_valid : s1_valid;
      chk("data_valid_passthru", 32'(tx_valid), 32'(sv));
    end
    if (tx_valid && tx_ready) begin
      chk("sb_underflow", 32'(exp_q.size() == 0), 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e.data));
        chk("tx_last", 32'(tx_last), 32'(e.last));
        chk("gnt", 32'(gnt), 32'(e.gnt));
        if (e.is_data) chk("src_ready", 32'({s1_ready, s0_ready}), 32'(e.gnt));
        else chk("src_ready_pre", 32'({s1_ready, s0_ready}), 0);
        if (e.last) last_acc = cyc;
      end
    end
    if (nlp_pulse) begin
      pulses++;
      if (nlp_mode) begin
        chk("nlp_interval", 32'(cyc - nlp_prev), NLP);
        nlp_prev = cyc;
      end
    end
    if (s0_valid && s0_ready) void'(src0.pop_front());
    if (s1_valid && s1_ready) void'(src1.pop_front());
    if (tx_valid && tx_ready && tx_last) gap_armed = (src0.size() + src1.size()) != 0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_frames(input int max_ticks);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_ticks) begin
      tick();
      n++;
    end
    chk("sb_drained", 32'(exp_q.size()), 0);
    chk("src_consumed", 32'(src0.size() + src1.size()), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_tx_last"}, 32'(tx_last), 0);
    chk({tag, "_ready"}, 32'({s0_ready, s1_ready}), 0);
    chk({tag, "_nlp"}, 32'(nlp_pulse), 0);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_led"}, 32'(led_tx), 0);
  endtask

  initial begin
    int n;
    resetn   = 1'b0;
    s0_data  = 8'h00;
    s0_valid = 1'b0;
    s0_last  = 1'b0;
    s1_data  = 8'h00;
    s1_valid = 1'b0;
    s1_last  = 1'b0;
    tx_ready = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;

    // Idle link pulses every NLP cycles, then a request lands on the expiry cycle.
    nlp_mode = 1;
    nlp_prev = cyc;
    pulses   = 0;
    repeat (NLP * 5 - 1) tick();
    chk("nlp_count", 32'(pulses), 4);
    nlp_mode    = 0;
    push_frame(0, 8'h11, 8'h11, 3);
    start_exp   = cyc + 1;
    first_valid = -1;
    led_cnt     = 0;
    run_frames(200);
    chk("frame_start", 32'(first_valid), 32'(start_exp));
    chk("led_cycles", 32'(led_cnt), 11);
    chk("nlp_suppressed", 32'(pulses), 4);

    // Backpressure and source bubbles on a single s1 frame.
    toggle = 1;
    bubble = 1;
    push_frame(1, 8'h61, 8'h01, 6);
    run_frames(300);
    toggle = 0;
    bubble = 0;

    // Both sources contending: s1 was granted last, so s0 leads the alternation.
    gaps = 0;
    push_frame(0, 8'h40, 8'h01, 2);
    push_frame(1, 8'h50, 8'h01, 2);
    push_frame(0, 8'h48, 8'h01, 2);
    push_frame(1, 8'h58, 8'h01, 2);
    run_frames(300);
    chk("gap_count", 32'(gaps), 3);

    // Asynchronous reset while the second data byte is on the bus.
    push_frame(0, 8'hA0, 8'h01, 5);
    n = 0;
    while (exp_q.size() > 4 && n < 100) begin
      tick();
      n++;
    end
    drive();
    #2;
    chk("pre_reset_valid", 32'(tx_valid), 1);
    chk("pre_reset_data", 32'(tx_data), 32'hA1);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    src0.delete();
    src1.delete();
    exp_q.delete();
    gap_armed = 0;
    drive();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs("reset_hold");
    @(negedge clk);
    resetn = 1'b1;
    push_frame(1, 8'hC1, 8'h01, 2);
    run_frames(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, required completion within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
